// File: rtl/mips_bus_ram.sv
// mips_bus_ram: word-addressed RAM slave for the mips_cpu_bus bus.
// Adds wait states, does byte-lane writes, and flags illegal accesses.
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   address      byte address from the CPU (word aligned)
//   read, write  transfer requests, held while waitrequest is high
//   waitrequest  slave stall (combinational)
//   writedata    write data
//   byteenable   lane n covers bits [8n+7:8n]
//   readdata     registered read data
//   bus_error    sticky illegal-access flag
module mips_bus_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        bus_error
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          accept;
    logic [31:0]   idx;
    logic [AW-1:0] widx;
    logic          in_range;
    logic          aligned;
    logic          is_zero;
    logic          ok;
    logic          legal;

    assign req         = read | write;
    assign accept      = req && ((WC == 4'd0) || (state == ACCEPT));
    assign waitrequest = req && !accept;

    assign idx      = (address - BASE_ADDR) >> 2;
    assign widx     = idx[AW-1:0];
    assign in_range = (address >= BASE_ADDR) && (idx < 32'(DEPTH));
    assign aligned  = (address[1:0] == 2'b00);
    assign is_zero  = (address == 32'h0);
    assign ok       = in_range && aligned;
    assign legal    = ok && !is_zero;

    // The IDLE cycle that first sees the request is itself a stall cycle,
    // so WAIT only needs to cover the remaining WAIT_CYCLES-1 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            readdata  <= '0;
            bus_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && (WC != 4'd0)) begin
                        if (WC == 4'd1) begin
                            state <= ACCEPT;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        bus_error <= 1'b1;
                    end else if (cnt + 4'd1 == WC) begin
                        state <= ACCEPT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ACCEPT: begin
                    state <= IDLE;
                    if (!req) bus_error <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (read && write) begin
                    readdata  <= '0;
                    bus_error <= 1'b1;
                end else if (read) begin
                    readdata <= legal ? mem[widx] : 32'h0;
                    if (!ok && !is_zero) bus_error <= 1'b1;
                end else if (!ok && !is_zero) begin
                    bus_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept && write && !read && legal) begin
            for (int n = 0; n < 4; n++) begin
                if (byteenable[n]) mem[widx][8*n +: 8] <= writedata[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_ram.sv
// tb_mips_bus_ram: scoreboard bench for mips_bus_ram.
// Three instances cover WAIT_CYCLES of 0, 3 and 4.
module tb_mips_bus_ram;
    localparam int ND = 3;
    localparam int WC [ND] = '{0, 3, 4};
    localparam logic [31:0] B = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        rd    [ND];
    logic        wr    [ND];
    logic        wreq  [ND];
    logic [31:0] rdata [ND];
    logic        berr  [ND];

    logic [31:0] exp_q [$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mips_bus_ram #(.WAIT_CYCLES(WC[g])) u_dut (
            .clk(clk), .reset(reset), .address(address),
            .write(wr[g]), .read(rd[g]), .waitrequest(wreq[g]),
            .writedata(writedata), .byteenable(byteenable),
            .readdata(rdata[g]), .bus_error(berr[g])
        );
        initial begin
            for (int i = 0; i < 64; i++) u_dut.mem[i] = 32'(i + 4);
            u_dut.mem[0] = 32'h3C08BFC0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic xfer(input int d, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int st);
        address = a;
        writedata = wd;
        byteenable = be;
        rd[d] = r;
        wr[d] = w;
        st = 0;
        @(negedge clk);
        while (wreq[d] && st < 40) begin
            st++;
            @(negedge clk);
        end
        total++;
        if (wreq[d]) begin
            bad++;
            $display("FAIL timeout dut%0d addr=%h stalls=%0d", d, a, st);
        end
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic issue_read(input int d, input logic [31:0] a,
                              input logic [31:0] e, output int st);
        exp_q.push_back(e);
        xfer(d, 1'b1, 1'b0, a, 32'h0, 4'h0, st);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            total++;
            if (rdata[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rdata[d]);
            end
            total++;
            if (berr[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_berr dut%0d got=%b exp=0", d, berr[d]);
            end
            total++;
            if (wreq[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_wreq dut%0d got=%b exp=0", d, wreq[d]);
            end
        end
    endtask

    task automatic test_zero_wait();
        int st;
        logic [31:0] e;
        issue_read(0, B, 32'h3C08BFC0, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e) begin
            bad++;
            $display("FAIL w0_read got=%h exp=%h", rdata[0], e);
        end
        total++;
        if (st != 0) begin
            bad++;
            $display("FAIL w0_stalls got=%0d exp=0", st);
        end
    endtask

    task automatic test_wait3();
        int st;
        logic [31:0] e;
        issue_read(1, B + 32'h2C, 32'd15, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[1] !== e) begin
            bad++;
            $display("FAIL w3_read got=%h exp=%h", rdata[1], e);
        end
        total++;
        if (st != 3) begin
            bad++;
            $display("FAIL w3_stalls got=%0d exp=3", st);
        end
    endtask

    task automatic test_byte_lanes();
        int st;
        logic [31:0] e;
        xfer(0, 1'b0, 1'b1, B + 32'h30, 32'hAABBCCDD, 4'b1111, st);
        xfer(0, 1'b0, 1'b1, B + 32'h30, 32'h00001100, 4'b0010, st);
        xfer(0, 1'b0, 1'b1, B + 32'h30, 32'hFFFFFFFF, 4'b0000, st);
        issue_read(0, B + 32'h30, 32'hAABB11DD, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e) begin
            bad++;
            $display("FAIL lanes_read got=%h exp=%h", rdata[0], e);
        end
        xfer(0, 1'b0, 1'b1, B + 32'h34, 32'h12345678, 4'b1111, st);
        total++;
        if (rdata[0] !== 32'hAABB11DD) begin
            bad++;
            $display("FAIL rdata_hold got=%h exp=aabb11dd", rdata[0]);
        end
        total++;
        if (berr[0] !== 1'b0) begin
            bad++;
            $display("FAIL lanes_berr got=%b exp=0", berr[0]);
        end
        xfer(1, 1'b0, 1'b1, B + 32'h30, 32'h77000000, 4'b1000, st);
        issue_read(1, B + 32'h30, 32'h77000010, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[1] !== e) begin
            bad++;
            $display("FAIL lane3_read got=%h exp=%h", rdata[1], e);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        logic [31:0] e;
        time t0;
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 1'b1, B + 32'h80 + 32'(4 * i),
                 32'(i * 3 + 1), 4'b1111, st);
        end
        total++;
        if ($time - t0 != 80) begin
            bad++;
            $display("FAIL b2b_time got=%0t exp=80", $time - t0);
        end
        for (int i = 0; i < 8; i++) begin
            issue_read(0, B + 32'h80 + 32'(4 * i), 32'(i * 3 + 1), st);
            e = exp_q.pop_front();
            total++;
            if (rdata[0] !== e) begin
                bad++;
                $display("FAIL b2b_read%0d got=%h exp=%h", i, rdata[0], e);
            end
        end
        for (int i = 1; i < 3; i++) begin
            issue_read(1, B + 32'(4 * i), 32'(i + 4), st);
            e = exp_q.pop_front();
            total++;
            if (rdata[1] !== e || st != 3) begin
                bad++;
                $display("FAIL b2b_w3_%0d got=%h/%0d exp=%h/3",
                         i, rdata[1], st, e);
            end
        end
    endtask

    task automatic test_addr_errors();
        int st;
        logic [31:0] e;
        issue_read(0, 32'h0, 32'h0, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e || berr[0] !== 1'b0) begin
            bad++;
            $display("FAIL read_zero got=%h/%b exp=%h/0", rdata[0], berr[0], e);
        end
        xfer(0, 1'b0, 1'b1, 32'h0, 32'h1234, 4'b1111, st);
        issue_read(0, B + 32'hFC, 32'd67, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e || berr[0] !== 1'b0) begin
            bad++;
            $display("FAIL last_word got=%h/%b exp=%h/0", rdata[0], berr[0], e);
        end
        issue_read(0, 32'h4, 32'h0, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e || berr[0] !== 1'b1) begin
            bad++;
            $display("FAIL read_four got=%h/%b exp=%h/1", rdata[0], berr[0], e);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (berr[0] !== 1'b1) begin
            bad++;
            $display("FAIL berr_sticky got=%b exp=1", berr[0]);
        end
        pulse_reset();
        total++;
        if (berr[0] !== 1'b0) begin
            bad++;
            $display("FAIL berr_clear got=%b exp=0", berr[0]);
        end
        issue_read(0, B + 32'h100, 32'h0, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e || berr[0] !== 1'b1) begin
            bad++;
            $display("FAIL past_end got=%h/%b exp=%h/1", rdata[0], berr[0], e);
        end
        pulse_reset();
        issue_read(0, B - 32'h4, 32'h0, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e || berr[0] !== 1'b1) begin
            bad++;
            $display("FAIL below_base got=%h/%b exp=%h/1", rdata[0], berr[0], e);
        end
        pulse_reset();
        xfer(0, 1'b0, 1'b1, B + 32'h32, 32'h55555555, 4'b1111, st);
        total++;
        if (berr[0] !== 1'b1) begin
            bad++;
            $display("FAIL unaligned_berr got=%b exp=1", berr[0]);
        end
        issue_read(0, B + 32'h30, 32'hAABB11DD, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[0] !== e) begin
            bad++;
            $display("FAIL unaligned_drop got=%h exp=%h", rdata[0], e);
        end
        pulse_reset();
    endtask

    task automatic test_rw_both();
        int st;
        logic [31:0] e;
        issue_read(1, B + 32'h4, 32'd5, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[1] !== e) begin
            bad++;
            $display("FAIL rw_pre got=%h exp=%h", rdata[1], e);
        end
        xfer(1, 1'b1, 1'b1, B, 32'hFFFFFFFF, 4'b1111, st);
        total++;
        if (rdata[1] !== 32'h0 || berr[1] !== 1'b1 || st != 3) begin
            bad++;
            $display("FAIL rw_both got=%h/%b/%0d exp=0/1/3",
                     rdata[1], berr[1], st);
        end
        pulse_reset();
        issue_read(1, B, 32'h3C08BFC0, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[1] !== e || berr[1] !== 1'b0) begin
            bad++;
            $display("FAIL rw_nowrite got=%h/%b exp=%h/0", rdata[1], berr[1], e);
        end
    endtask

    task automatic test_withdraw();
        int st;
        int hi;
        logic [31:0] e;
        issue_read(2, B + 32'h4, 32'd5, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[2] !== e || st != 4) begin
            bad++;
            $display("FAIL w4_read got=%h/%0d exp=%h/4", rdata[2], st, e);
        end
        address = B + 32'h40;
        writedata = 32'hDEADBEEF;
        byteenable = 4'b1111;
        wr[2] = 1'b1;
        hi = 0;
        repeat (2) begin
            @(negedge clk);
            if (wreq[2]) hi++;
            @(posedge clk);
            #1;
        end
        wr[2] = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (hi != 2 || berr[2] !== 1'b1 || wreq[2] !== 1'b0) begin
            bad++;
            $display("FAIL withdraw got=%0d/%b/%b exp=2/1/0",
                     hi, berr[2], wreq[2]);
        end
        issue_read(2, B + 32'h40, 32'd20, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[2] !== e || st != 4) begin
            bad++;
            $display("FAIL withdraw_mem got=%h/%0d exp=%h/4", rdata[2], st, e);
        end
        pulse_reset();
        total++;
        if (berr[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            bad++;
            $display("FAIL withdraw_reset got=%b/%h exp=0/0", berr[2], rdata[2]);
        end
        address = B + 32'h44;
        writedata = 32'h0;
        wr[2] = 1'b1;
        @(posedge clk);
        #1;
        wr[2] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue_read(2, B + 32'h44, 32'd21, st);
        e = exp_q.pop_front();
        total++;
        if (rdata[2] !== e || berr[2] !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort got=%h/%b exp=%h/0", rdata[2], berr[2], e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        address = '0;
        writedata = '0;
        byteenable = '0;
        for (int d = 0; d < ND; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait3();
        test_byte_lanes();
        test_back_to_back();
        test_addr_errors();
        test_rw_both();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
